// File: rtl/bsg_fifo_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bsg_fifo_word_serializer
// Description : Drain stage for a 1r1w FIFO. Pops full words and emits them
//               as narrower chunks on a valid/ready port with a last flag,
//               one chunk per cycle and no bubble between words.
// Revision    : 1.0  initial release
// ============================================================================
module bsg_fifo_word_serializer #(
    parameter int width_p     = 16,
    parameter int out_width_p = 4,
    parameter int msb_first_p = 0
) (
    input  logic                   clk_i,
    input  logic                   reset_n_i,
    input  logic                   v_i,
    input  logic [width_p-1:0]     data_i,
    output logic                   yumi_o,
    output logic                   v_o,
    output logic [out_width_p-1:0] data_o,
    output logic                   last_o,
    input  logic                   ready_i
);

    localparam int c_RATIO = width_p / out_width_p;
    localparam int c_CNT_W = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_RATIO - 1);

    localparam logic [0:0] c_ST_IDLE  = 1'b0;
    localparam logic [0:0] c_ST_SHIFT = 1'b1;

    // Word width must split into a whole number of chunks.
    if ((width_p % out_width_p) != 0) begin : g_bad_ratio
        $error("bsg_fifo_word_serializer: width_p must be a multiple of out_width_p");
    end

    logic [0:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cnt_q,   cnt_d;
    logic [width_p-1:0] shift_q, shift_d;

    logic [width_p-1:0]     w_shifted;
    logic [out_width_p-1:0] w_chunk;
    logic                   w_last;
    logic                   w_handshake;

    // Chunk selection and shift direction depend on the emit order. With a
    // single chunk per word the shifted value is never used.
    if (c_RATIO == 1) begin : g_ratio1
        assign w_shifted = '0;
        assign w_chunk   = shift_q[out_width_p-1:0];
    end else if (msb_first_p != 0) begin : g_msb
        assign w_shifted = shift_q << out_width_p;
        assign w_chunk   = shift_q[width_p-1 -: out_width_p];
    end else begin : g_lsb
        assign w_shifted = shift_q >> out_width_p;
        assign w_chunk   = shift_q[out_width_p-1:0];
    end

    assign w_last      = (state_q == c_ST_SHIFT) && (cnt_q == c_CNT_LAST);
    assign w_handshake = (state_q == c_ST_SHIFT) && ready_i;

    // State, chunk counter and shift register; async clear drops any held word.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= c_ST_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end

    // Next state: load on pop, shift on mid-word handshake, reload or idle at word end.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        case (state_q)
            c_ST_IDLE: begin
                if (v_i) begin
                    state_d = c_ST_SHIFT;
                    cnt_d   = '0;
                    shift_d = data_i;
                end
            end
            c_ST_SHIFT: begin
                if (w_handshake) begin
                    if (!w_last) begin
                        cnt_d   = cnt_q + c_CNT_W'(1);
                        shift_d = w_shifted;
                    end else if (v_i) begin
                        cnt_d   = '0;
                        shift_d = data_i;
                    end else begin
                        state_d = c_ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    // Outputs: chunk port decoded from registers; pop is the only path from ready_i.
    always_comb begin
        v_o    = (state_q == c_ST_SHIFT);
        last_o = w_last;
        data_o = w_chunk;
        // Gated by reset so the FIFO is never popped while this block is held clear.
        yumi_o = reset_n_i & v_i & ((state_q == c_ST_IDLE) | (w_handshake & w_last));
    end

endmodule
`default_nettype wire

// File: tb/tb_bsg_fifo_word_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsg_fifo_word_serializer
// Description : Directed and random checks of the word serializer, with a
//               small FIFO model on the read side. An MSB-first instance
//               shares the same inputs.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bsg_fifo_word_serializer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        v_i;
    logic [15:0] data_i;
    logic        yumi_o;
    logic        v_o;
    logic [3:0]  data_o;
    logic        last_o;
    logic        ready_i;

    logic        yumi_m;
    logic        v_m;
    logic [3:0]  data_m;
    logic        last_m;

    int n_err = 0;
    int n_chk = 0;

    // FIFO model: written by the stimulus, popped on yumi_o.
    logic [15:0] mem [0:15];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign v_i    = (wr_ptr != rd_ptr);
    assign data_i = mem[rd_ptr % 16];

    always #5 clk_i = ~clk_i;

    bsg_fifo_word_serializer #(
        .width_p     (16),
        .out_width_p (4),
        .msb_first_p (0)
    ) dut (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .yumi_o    (yumi_o),
        .v_o       (v_o),
        .data_o    (data_o),
        .last_o    (last_o),
        .ready_i   (ready_i)
    );

    bsg_fifo_word_serializer #(
        .width_p     (16),
        .out_width_p (4),
        .msb_first_p (1)
    ) dut_msb (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .data_i    (data_i),
        .yumi_o    (yumi_m),
        .v_o       (v_m),
        .data_o    (data_m),
        .last_o    (last_m),
        .ready_i   (ready_i)
    );

    // Monitor: pops the FIFO model, counts pops, reassembles LSB-first words.
    int          n_yumi   = 0;
    int          n_yumi_bad = 0;
    int          nib      = 0;
    logic [15:0] acc      = '0;
    logic [15:0] got_q [$];

    always @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            nib = 0;
            acc = '0;
        end else begin
            if (yumi_o) begin
                n_yumi = n_yumi + 1;
                if (!v_i) n_yumi_bad = n_yumi_bad + 1;
                rd_ptr = rd_ptr + 1;
            end
            if (v_o && ready_i) begin
                acc[nib*4 +: 4] = data_o;
                if (last_o) begin
                    got_q.push_back(acc);
                    nib = 0;
                    acc = '0;
                end else begin
                    nib = nib + 1;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        mem[wr_ptr % 16] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    // Checks the LSB instance chunk presented in the current cycle.
    task automatic expect_chunk(input string tag, input logic [3:0] d, input logic l);
        check({tag, "_v"},    {31'd0, v_o},    32'd1);
        check({tag, "_data"}, {28'd0, data_o}, {28'd0, d});
        check({tag, "_last"}, {31'd0, last_o}, {31'd0, l});
    endtask

    logic [3:0]  seq [0:7];
    logic [15:0] words [0:7];
    int          y0;
    int          base;

    initial begin
        reset_n_i = 1'b0;
        ready_i   = 1'b0;
        repeat (3) step();

        // Reset state
        check("rst_v",    {31'd0, v_o},    32'd0);
        check("rst_last", {31'd0, last_o}, 32'd0);
        check("rst_data", {28'd0, data_o}, 32'd0);
        check("rst_yumi", {31'd0, yumi_o}, 32'd0);
        reset_n_i = 1'b1;
        step();
        check("idle_v", {31'd0, v_o}, 32'd0);

        // T1: LSB-first single word
        y0 = n_yumi;
        push(16'hABCD);
        ready_i = 1'b1;
        #1;
        check("t1_yumi_pop", {31'd0, yumi_o}, 32'd1);
        seq[0] = 4'hD; seq[1] = 4'hC; seq[2] = 4'hB; seq[3] = 4'hA;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_chunk($sformatf("t1_c%0d", i), seq[i], i == 3);
            check($sformatf("t1_c%0d_yumi", i), {31'd0, yumi_o}, 32'd0);
        end
        step();
        check("t1_end_v", {31'd0, v_o}, 32'd0);
        check("t1_npop", n_yumi - y0, 32'd1);

        // T2: back-to-back words with no gap
        push(16'h1234);
        push(16'h5678);
        #1;
        check("t2_yumi_pop", {31'd0, yumi_o}, 32'd1);
        seq[0] = 4'h4; seq[1] = 4'h3; seq[2] = 4'h2; seq[3] = 4'h1;
        seq[4] = 4'h8; seq[5] = 4'h7; seq[6] = 4'h6; seq[7] = 4'h5;
        for (int i = 0; i < 8; i++) begin
            step();
            expect_chunk($sformatf("t2_c%0d", i), seq[i], (i == 3) || (i == 7));
            check($sformatf("t2_c%0d_yumi", i), {31'd0, yumi_o}, (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        check("t2_end_v", {31'd0, v_o}, 32'd0);

        // T3: backpressure holds chunk C
        y0 = n_yumi;
        push(16'hABCD);
        step();
        expect_chunk("t3_d", 4'hD, 1'b0);
        step();
        ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            expect_chunk($sformatf("t3_hold%0d", i), 4'hC, 1'b0);
            check($sformatf("t3_hold%0d_yumi", i), {31'd0, yumi_o}, 32'd0);
        end
        step();
        ready_i = 1'b1;
        expect_chunk("t3_c", 4'hC, 1'b0);
        step();
        expect_chunk("t3_b", 4'hB, 1'b0);
        step();
        expect_chunk("t3_a", 4'hA, 1'b1);
        step();
        check("t3_npop", n_yumi - y0, 32'd1);

        // T4: MSB-first instance
        push(16'hABCD);
        seq[0] = 4'hA; seq[1] = 4'hB; seq[2] = 4'hC; seq[3] = 4'hD;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("t4_c%0d_v", i),    {31'd0, v_m},    32'd1);
            check($sformatf("t4_c%0d_data", i), {28'd0, data_m}, {28'd0, seq[i]});
            check($sformatf("t4_c%0d_last", i), {31'd0, last_m}, (i == 3) ? 32'd1 : 32'd0);
        end
        step();

        // T5: async reset mid-word, next word queued
        push(16'hABCD);
        push(16'h1234);
        step();
        expect_chunk("t5_d", 4'hD, 1'b0);
        step();
        expect_chunk("t5_c", 4'hC, 1'b0);
        step();
        reset_n_i = 1'b0;
        #1;
        check("t5_rst_v",    {31'd0, v_o},    32'd0);
        check("t5_rst_yumi", {31'd0, yumi_o}, 32'd0);
        check("t5_rst_last", {31'd0, last_o}, 32'd0);
        step();
        check("t5_held_v",    {31'd0, v_o},    32'd0);
        check("t5_held_yumi", {31'd0, yumi_o}, 32'd0);
        reset_n_i = 1'b1;
        #1;
        check("t5_rel_yumi", {31'd0, yumi_o}, 32'd1);
        seq[0] = 4'h4; seq[1] = 4'h3; seq[2] = 4'h2; seq[3] = 4'h1;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_chunk($sformatf("t5_c%0d", i), seq[i], i == 3);
        end
        step();
        check("t5_end_v", {31'd0, v_o}, 32'd0);

        // T6: random words, random ready duty cycle, scoreboard
        base = got_q.size();
        for (int i = 0; i < 8; i++) begin
            words[i] = 16'($urandom);
            push(words[i]);
        end
        for (int c = 0; c < 400 && got_q.size() < base + 8; c++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            step();
        end
        ready_i = 1'b1;
        check("t6_count", got_q.size(), base + 8);
        if (got_q.size() >= base + 8) begin
            for (int i = 0; i < 8; i++)
                check($sformatf("t6_word%0d", i), {16'd0, got_q[base + i]}, {16'd0, words[i]});
        end
        check("yumi_without_v", n_yumi_bad, 32'd0);
        step();
        check("t6_end_v", {31'd0, v_o}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
